// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master with an 8-bit register port, all four SPI modes,
// a programmable SCK divider and byte FIFOs on both the TX and RX paths.

module spi_master_mc_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full,
    output logic       dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; the count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module spi_master_mc #(
    parameter int         NCS        = 4,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] DIV_RESET  = 8'd5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     reg_addr,
    input  logic [7:0]     reg_wdata,
    input  logic           reg_wr_en,
    input  logic           reg_rd_en,
    output logic [7:0]     reg_rdata,
    output logic           spi_sck,
    output logic           spi_mosi,
    input  logic           spi_miso,
    output logic [NCS-1:0] spi_csn
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] cs_sel;
    logic       cpha, cpol;
    logic [7:0] div, div_cur, hp_cnt;
    logic [3:0] edge_cnt;
    logic       sck_tog, mosi;
    logic [7:0] tx_sh, rx_sh;
    logic       rx_overrun, tx_overflow;

    logic       tx_pop, rx_push, hp_end, busy;
    logic       wr_ctrl, wr_data, wr_div, rd_data, rd_stat;
    logic [7:0] tx_head, rx_head, stat;
    logic       tx_empty, tx_full, tx_drop;
    logic       rx_empty, rx_full, rx_drop;

    assign busy    = (state != IDLE);
    assign wr_ctrl = reg_wr_en && (reg_addr == 2'd0) && !busy;
    assign wr_data = reg_wr_en && (reg_addr == 2'd2);
    assign wr_div  = reg_wr_en && (reg_addr == 2'd3);
    assign rd_stat = reg_rd_en && (reg_addr == 2'd1);
    assign rd_data = reg_rd_en && (reg_addr == 2'd2);
    assign hp_end  = (state == SHIFT) && (hp_cnt == div_cur);
    assign stat    = {1'b0, tx_overflow, rx_overrun, rx_full, rx_empty, tx_full, tx_empty, busy};

    spi_master_mc_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(wr_data), .push_data(reg_wdata), .pop(tx_pop),
        .head(tx_head), .empty(tx_empty), .full(tx_full), .dropped(tx_drop)
    );

    spi_master_mc_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_sh), .pop(rd_data),
        .head(rx_head), .empty(rx_empty), .full(rx_full), .dropped(rx_drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (hp_end && (edge_cnt == 4'd15)) state_nxt = DONE;
            end
            DONE: begin
                rx_push = 1'b1;
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Even edge counts are leading edges; the shifting edge is leading for CPHA=1, trailing for CPHA=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_cnt   <= '0;
            edge_cnt <= '0;
            sck_tog  <= 1'b0;
            div_cur  <= DIV_RESET;
            tx_sh    <= 8'hFF;
            rx_sh    <= '0;
            mosi     <= 1'b1;
        end else if (tx_pop) begin
            hp_cnt   <= '0;
            edge_cnt <= '0;
            sck_tog  <= 1'b0;
            div_cur  <= div;
            if (cpha) begin
                tx_sh <= tx_head;
            end else begin
                mosi  <= tx_head[7];
                tx_sh <= {tx_head[6:0], 1'b1};
            end
        end else if (hp_end) begin
            hp_cnt   <= '0;
            edge_cnt <= edge_cnt + 1'b1;
            sck_tog  <= ~sck_tog;
            if (edge_cnt[0] != cpha) begin
                mosi  <= tx_sh[7];
                tx_sh <= {tx_sh[6:0], 1'b1};
            end else begin
                rx_sh <= {rx_sh[6:0], spi_miso};
            end
        end else if (state == SHIFT) begin
            hp_cnt <= hp_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sel      <= '0;
            cpha        <= 1'b0;
            cpol        <= 1'b0;
            div         <= DIV_RESET;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            reg_rdata   <= '0;
        end else begin
            if (wr_ctrl) begin
                cs_sel <= reg_wdata[2:0];
                cpha   <= reg_wdata[3];
                cpol   <= reg_wdata[4];
            end
            if (wr_div) div <= reg_wdata;
            // A new event in the same cycle as a STAT read wins over the clear.
            if (rx_drop)      rx_overrun <= 1'b1;
            else if (rd_stat) rx_overrun <= 1'b0;
            if (tx_drop)      tx_overflow <= 1'b1;
            else if (rd_stat) tx_overflow <= 1'b0;
            if (reg_rd_en) begin
                case (reg_addr)
                    2'd0:    reg_rdata <= {3'b000, cpol, cpha, cs_sel};
                    2'd1:    reg_rdata <= stat;
                    2'd2:    reg_rdata <= rx_empty ? 8'h00 : rx_head;
                    default: reg_rdata <= div;
                endcase
            end
        end
    end

    // The toggle count is zero outside a byte, so SCK follows CPOL directly while idle.
    assign spi_sck  = cpol ^ sck_tog;
    assign spi_mosi = mosi;

    always_comb begin
        for (int k = 0; k < NCS; k++) spi_csn[k] = (cs_sel != 3'(k + 1));
    end
endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: MISO is looped back as ~MOSI, so every
// received byte is the complement of the byte sent.

module tb_spi_master_mc;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] reg_addr = '0;
    logic [7:0] reg_wdata = '0;
    logic       reg_wr_en = 1'b0;
    logic       reg_rd_en = 1'b0;
    logic [7:0] reg_rdata;
    logic       spi_sck, spi_mosi, spi_miso;
    logic [3:0] spi_csn;

    int total = 0;
    int bad = 0;

    spi_master_mc #(.NCS(4), .FIFO_DEPTH(8), .DIV_RESET(8'd5)) dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_csn(spi_csn)
    );

    always #5 clk = ~clk;
    assign spi_miso = ~spi_mosi;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // All register tasks start and end on a falling edge; each access takes one cycle.
    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        reg_addr = a; reg_wdata = d; reg_wr_en = 1'b1;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [7:0] expected, input string tag);
        reg_addr = a; reg_rd_en = 1'b1;
        @(negedge clk);
        reg_rd_en = 1'b0;
        check(tag, reg_rdata, expected);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] pat;
    logic        sck_log [140];
    int          csn_bad;
    logic [7:0]  mode_ctrl [4] = '{8'h02, 8'h0A, 8'h12, 8'h1A};

    initial begin
        // Power-on reset
        idle(3);
        check("rst_csn", spi_csn, 4'hF);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b1);
        check("rst_rdata", reg_rdata, 8'h00);
        rst = 1'b0;
        idle(2);
        read_check(2'd1, 8'h0A, "rst_stat");
        read_check(2'd3, 8'h05, "rst_div");
        read_check(2'd0, 8'h00, "rst_ctrl");

        // Mode 0, DIV=0, 0x03 looped back
        reg_write(2'd0, 8'h01);
        check("m0_csn", spi_csn, 4'b1110);
        reg_write(2'd3, 8'h00);
        reg_write(2'd2, 8'h03);
        read_check(2'd1, 8'h08, "m0_stat_t1");
        read_check(2'd1, 8'h0B, "m0_stat_t2");
        pat = '0;
        for (int i = 0; i < 16; i++) begin
            pat = {pat[14:0], spi_sck};
            @(negedge clk);
        end
        check("m0_sck_pattern", pat, 16'hAAAA);
        read_check(2'd1, 8'h02, "m0_stat_rx");
        read_check(2'd2, 8'hFC, "m0_rx");
        read_check(2'd1, 8'h0A, "m0_stat_end");

        // All four modes on CS 2
        for (int m = 0; m < 4; m++) begin
            reg_write(2'd0, mode_ctrl[m]);
            check($sformatf("mode%0d_csn", m), spi_csn, 4'b1101);
            check($sformatf("mode%0d_sck_idle", m), spi_sck, m / 2);
            reg_write(2'd2, 8'hA5);
            idle(4);
            check($sformatf("mode%0d_sck_active", m), spi_sck, (m / 2) ^ 1);
            idle(21);
            check($sformatf("mode%0d_sck_after", m), spi_sck, m / 2);
            read_check(2'd2, 8'h5A, $sformatf("mode%0d_rx", m));
        end

        // FIFO stress: 10 writes; first goes to the engine, 8 fill TX, last is dropped
        reg_write(2'd0, 8'h01);
        reg_write(2'd3, 8'h03);
        for (int i = 0; i < 10; i++) reg_write(2'd2, 8'h10 + 8'(i));
        idle(700);
        read_check(2'd1, 8'h72, "stress_stat_flags");
        read_check(2'd1, 8'h12, "stress_stat_cleared");
        for (int i = 0; i < 8; i++)
            read_check(2'd2, ~(8'h10 + 8'(i)), $sformatf("stress_rx%0d", i));
        read_check(2'd2, 8'h00, "stress_rx_empty_read");
        read_check(2'd1, 8'h0A, "stress_stat_end");

        // DIV=3, 0x00 then 0xFF back to back
        reg_write(2'd2, 8'h00);
        reg_write(2'd2, 8'hFF);
        csn_bad = 0;
        for (int i = 0; i < 140; i++) begin
            sck_log[i] = spi_sck;
            if (i < 129 && spi_csn !== 4'b1110) csn_bad++;
            @(negedge clk);
        end
        check("b2b_sck_before_first", sck_log[3], 1'b0);
        check("b2b_sck_first_edge", sck_log[4], 1'b1);
        check("b2b_sck_half_period", sck_log[7], 1'b1);
        check("b2b_sck_second_edge", sck_log[8], 1'b0);
        check("b2b_sck_gap", sck_log[68], 1'b0);
        check("b2b_sck_byte2_first", sck_log[69], 1'b1);
        check("b2b_csn_held", csn_bad, 0);
        read_check(2'd2, 8'hFF, "b2b_rx0");
        read_check(2'd2, 8'h00, "b2b_rx1");
        read_check(2'd1, 8'h0A, "b2b_stat_end");

        // CTRL write while busy is dropped
        reg_write(2'd2, 8'h55);
        idle(5);
        reg_write(2'd0, 8'h03);
        check("busy_ctrl_csn", spi_csn, 4'b1110);
        idle(80);
        check("busy_ctrl_csn_idle", spi_csn, 4'b1110);
        read_check(2'd0, 8'h01, "busy_ctrl_readback");
        read_check(2'd2, 8'hAA, "busy_ctrl_rx");
        reg_write(2'd0, 8'h13);
        check("idle_ctrl_csn", spi_csn, 4'b1011);
        check("idle_ctrl_sck", spi_sck, 1'b1);

        // Reset mid-byte
        reg_write(2'd3, 8'h07);
        reg_write(2'd2, 8'h3C);
        idle(20);
        rst = 1'b1;
        #1;
        check("midrst_csn", spi_csn, 4'hF);
        check("midrst_sck", spi_sck, 1'b0);
        check("midrst_mosi", spi_mosi, 1'b1);
        check("midrst_rdata", reg_rdata, 8'h00);
        idle(3);
        rst = 1'b0;
        idle(10);
        read_check(2'd1, 8'h0A, "midrst_stat");
        read_check(2'd3, 8'h05, "midrst_div");
        read_check(2'd0, 8'h00, "midrst_ctrl");
        read_check(2'd2, 8'h00, "midrst_rx_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
